ide_xfer_fifo: RTL and testbench
================================

Name: ide_xfer_fifo

Overview:
- Word buffer between the AVR external-SRAM-style bus and the IDE data register path of ide_interface.
- The AVR moves sector data byte-wise through a 4-register window; the host side moves 16-bit words in a single cycle.
- One direction at a time, selected by a control bit:
  - dir=1: AVR to host (PIO read data).
  - dir=0: host to AVR (PIO write data).

Parameters:
- DEPTH_LOG2, 8, log2 of buffer depth in 16-bit words (256 words = 512-byte sector).
- LEVEL_W, 8, width of the LEVEL register; the count saturates at 2^LEVEL_W-1.

Ports:
- clk  input  1  system clock, shared with avr and ide_interface.
- nrst  input  1  synchronous, active-low reset.
- sram_a  input  2  register select: 0 DATA, 1 STATUS, 2 CONTROL, 3 LEVEL.
- sram_cs  input  1  access select.
- sram_oe  input  1  read enable.
- sram_we  input  1  write enable.
- sram_d_in  input  8  write data from AVR.
- sram_d_out  output  8  read data to AVR.
- sram_wait  output  1  stall request to AVR.
- h_rd_data  output  16  head word toward host (dir=1).
- h_rd_valid  output  1  h_rd_data is valid.
- h_rd_ack  input  1  pop head word; honoured only when h_rd_valid=1.
- h_wr_data  input  16  word from host (dir=0).
- h_wr_stb  input  1  push h_wr_data; honoured only when not full.
- h_wr_full  output  1  buffer full in dir=0.
- dir  output  1  current direction.
- irq  output  1  level interrupt to AVR.

Behaviour:
- Reset (nrst=0 at a clk edge):
  - pointers and count = 0; dir = 0; error flags = 0; byte-pending flag = 0.
  - sram_d_out = 0, sram_wait = 0, h_rd_valid = 0, h_wr_full = 0, irq = 0.
  - Applies mid-transfer; buffered contents are discarded.
- Access framing:
  - Start = cycle where sram_cs=1 and the previous cycle had sram_cs=0.
  - End = first cycle where sram_cs=0 after a start.
  - Writes commit at start.
  - Reads: sram_d_out is a combinational mux of the selected register during cs; a DATA pop commits at end.
- DATA write (dir=1 only; ignored when dir=0):
  - Even write latches the low byte and sets pending.
  - Odd write forms {high, low}, pushes the word and clears pending.
  - Push when full: word dropped, overflow=1.
- DATA read (dir=0 only; reads 0 when dir=1):
  - Returns the low byte, then the high byte of the head word.
  - The head word is popped at the end of the high-byte read.
  - Read when empty: returns 0x00, underflow=1, no pointer change.
- STATUS, bit by bit:
  - bit0 empty.
  - bit1 full.
  - bit2 dir.
  - bit3 overflow.
  - bit4 underflow.
  - bit5 byte pending.
  - bit6 half-full (count >= 2^(DEPTH_LOG2-1)).
  - bit7 0.
- CONTROL write, bit by bit:
  - bit0 flush: pointers, count and pending cleared.
  - bit1 new dir value; any change of dir also flushes.
  - bit2 clears overflow and underflow.
  - bit3 irq enable.
  - CONTROL read returns {4'b0, irq_en, 1'b0, dir, 1'b0}.
- LEVEL read: word count, saturated to LEVEL_W bits.
- Storage and host side:
  - Storage is a synchronous-read RAM plus a show-ahead head register.
  - A word pushed into an empty buffer appears on h_rd_data with h_rd_valid=1 exactly 2 cycles after the push cycle.
  - Steady-state h_rd_ack every cycle sustains one word per cycle.
  - h_wr_full = (count == 2^DEPTH_LOG2) && dir==0.
  - h_rd_valid is forced to 0 when dir=0.
- Simultaneous push and pop in one cycle: count unchanged; legal at full (pop first) and at empty-with-head-valid.
- Pointers wrap modulo 2^DEPTH_LOG2; count ranges 0..2^DEPTH_LOG2 inclusive.
- irq = irq_en && (dir ? empty : half-full), registered with 1 cycle latency.

Optional Feature:
- IDE_XFER_FIFO_WAIT_EN defined:
  - A DATA access that would overflow or underflow holds sram_wait=1 from start until the condition clears; the access then completes normally.
  - Overflow and underflow are never set by AVR accesses.
  - A flush or a dir change releases the wait; the stalled access is then discarded.
- Not defined: sram_wait is tied to 0 and the error flags behave as above.

Decomposition:
- Shared package ide_xfer_pkg holds:
  - register address constants REG_DATA/REG_STATUS/REG_CONTROL/REG_LEVEL;
  - STATUS and CONTROL bit-index constants;
  - the default DEPTH_LOG2.
- One natural sub-module: ide_xfer_ram, a parameterised simple dual-port synchronous RAM, 16 x 2^DEPTH_LOG2.

Test Plan:
- Reset: nrst low for 2 cycles mid-transfer with 5 words queued -> STATUS=0x01, LEVEL=0, h_rd_valid=0, sram_wait=0.
- dir=1: AVR writes bytes 0x34,0x12 to DATA -> h_rd_data=0x1234, h_rd_valid=1 two cycles after the second write; h_rd_ack -> STATUS bit0=1.
- Full: 256 words pushed with dir=1, then one more word -> LEVEL=255 (saturated), STATUS bit1=1 and bit3=1; CONTROL=0x06 -> bit3 cleared.
- dir=0: host pushes 0xBEEF, 0xCAFE -> AVR DATA reads return 0xEF,0xBE,0xFE,0xCA; a fifth read returns 0x00 with STATUS bit4=1.
- Simultaneous h_wr_stb at full with AVR pop ending in the same cycle -> count stays 256; the new word is read last; no overflow.
- IDE_XFER_FIFO_WAIT_EN, dir=0, empty: AVR DATA read -> sram_wait=1 held; host pushes 0x00AA -> wait drops; read returns 0xAA; underflow stays 0.

Source files
------------

// File: rtl/ide_xfer_pkg.sv
// Shared constants for the IDE transfer word buffer:
// AVR register map, STATUS/CONTROL bit positions, default sizes.
package ide_xfer_pkg;

   localparam int DEPTH_LOG2_DEF = 8;
   localparam int LEVEL_W_DEF    = 8;

   localparam logic [1:0] REG_DATA    = 2'd0;
   localparam logic [1:0] REG_STATUS  = 2'd1;
   localparam logic [1:0] REG_CONTROL = 2'd2;
   localparam logic [1:0] REG_LEVEL   = 2'd3;

   localparam int ST_EMPTY = 0;
   localparam int ST_FULL  = 1;
   localparam int ST_DIR   = 2;
   localparam int ST_OVF   = 3;
   localparam int ST_UNF   = 4;
   localparam int ST_PEND  = 5;
   localparam int ST_HALF  = 6;

   localparam int CT_FLUSH = 0;
   localparam int CT_DIR   = 1;
   localparam int CT_CLR   = 2;
   localparam int CT_IRQEN = 3;

endpackage

// File: rtl/ide_xfer_ram.sv
// Simple dual-port synchronous RAM, one write and one registered read port.
// Ports: clk; we_i/waddr_i/wdata_i write; raddr_i in, rdata_o one cycle later.
module ide_xfer_ram #(
   parameter int AW = 8,
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [DW-1:0] wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [DW-1:0] rdata_o
);

   logic [DW-1:0] mem_q [(1 << AW)];

   // Read returns the old word on a same-address write.
   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      rdata_o <= mem_q[raddr_i];
   end

endmodule

// File: rtl/ide_xfer_fifo.sv
// Word buffer between the AVR byte register window and the IDE host word path.
// Ports: clk/nrst; sram_* AVR window (DATA/STATUS/CONTROL/LEVEL), sram_wait stall;
// h_rd_* head word toward host (dir=1); h_wr_* words from host (dir=0); dir; irq.
// Build option IDE_XFER_FIFO_WAIT_EN: stall blocked DATA accesses instead of
// flagging overflow/underflow.
module ide_xfer_fifo
   import ide_xfer_pkg::*;
#(
   parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
   parameter int LEVEL_W    = LEVEL_W_DEF
) (
   input  logic        clk,
   input  logic        nrst,
   input  logic [1:0]  sram_a,
   input  logic        sram_cs,
   input  logic        sram_oe,
   input  logic        sram_we,
   input  logic [7:0]  sram_d_in,
   output logic [7:0]  sram_d_out,
   output logic        sram_wait,
   output logic [15:0] h_rd_data,
   output logic        h_rd_valid,
   input  logic        h_rd_ack,
   input  logic [15:0] h_wr_data,
   input  logic        h_wr_stb,
   output logic        h_wr_full,
   output logic        dir,
   output logic        irq
);

   localparam int AW    = DEPTH_LOG2;
   localparam int CW    = DEPTH_LOG2 + 1;
   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [CW-1:0] HALF_CNT = CW'(DEPTH / 2);
   localparam int LVL_MAX = (1 << LEVEL_W) - 1;

   logic          cs_q;
   logic          dir_q, dir_d;
   logic          irq_en_q, irq_en_d;
   logic          ovf_q, ovf_d;
   logic          unf_q, unf_d;
   logic          pend_q, pend_d;
   logic [7:0]    lo_q, lo_d;
   logic          rd_live_q, rd_live_d;
   logic [AW-1:0] wptr_q, wptr_d;
   logic [AW-1:0] rptr_q, rptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          head_v_q, head_v_d;
   logic          irq_q, irq_d;

   logic          start, fin, a_data, ctrl_wr, flush;
   logic          full, empty, half;
   logic          wr_go, rd_start, rd_go;
   logic [7:0]    wr_byte;
   logic          hpop, apop, pop, apush, hpush, push;
   logic [15:0]   push_word, q;
   logic [AW-1:0] raddr;
   logic [7:0]    status, level_b;

   assign start    = sram_cs & ~cs_q;
   assign fin      = ~sram_cs & cs_q;
   assign a_data   = sram_a == REG_DATA;
   assign ctrl_wr  = start & sram_we & (sram_a == REG_CONTROL);
   assign flush    = ctrl_wr &
                     (sram_d_in[CT_FLUSH] | (sram_d_in[CT_DIR] != dir_q));
   assign full     = count_q == FULL_CNT;
   assign empty    = count_q == '0;
   assign half     = count_q >= HALF_CNT;
   assign rd_start = start & sram_oe & a_data & ~dir_q;
   assign rd_go    = fin & rd_live_q;

`ifdef IDE_XFER_FIFO_WAIT_EN
   localparam logic ERR_EN = 1'b0;
   logic       hold_q, hold_d;
   logic [7:0] hbyte_q;
   logic       wr_cand;

   // A blocked high-byte write parks here until a slot opens.
   assign wr_cand   = (start & sram_we & a_data & dir_q) | hold_q;
   assign wr_byte   = hold_q ? hbyte_q : sram_d_in;
   assign wr_go     = wr_cand & ~(pend_q & full);
   assign hold_d    = wr_cand & ~wr_go & sram_cs & ~flush;
   assign sram_wait = sram_cs &
                      ((wr_cand & ~wr_go) |
                       ((rd_start | rd_live_q) & ~head_v_q));

   always_ff @(posedge clk) begin
      if (!nrst) begin
         hold_q  <= 1'b0;
         hbyte_q <= 8'h00;
      end else begin
         hold_q <= hold_d;
         if (wr_cand && !hold_q) hbyte_q <= sram_d_in;
      end
   end
`else
   localparam logic ERR_EN = 1'b1;

   assign wr_go     = start & sram_we & a_data & dir_q;
   assign wr_byte   = sram_d_in;
   assign sram_wait = 1'b0;
`endif

   // Pop before push, so a full buffer accepts a word in a pop cycle.
   assign hpop  = dir_q & h_rd_ack & head_v_q;
   assign apop  = rd_go & head_v_q & pend_q;
   assign pop   = hpop | apop;
   assign apush = wr_go & pend_q & (~full | pop);
   assign hpush = ~dir_q & h_wr_stb & (~full | pop);
   assign push  = apush | hpush;

   assign push_word = apush ? {wr_byte, lo_q} : h_wr_data;
   assign raddr     = pop ? rptr_q + AW'(1) : rptr_q;

   ide_xfer_ram #(
      .AW (AW),
      .DW (16)
   ) u_ram (
      .clk     (clk),
      .we_i    (push),
      .waddr_i (wptr_q),
      .wdata_i (push_word),
      .raddr_i (raddr),
      .rdata_o (q)
   );

   always_comb begin
      dir_d     = dir_q;
      irq_en_d  = irq_en_q;
      ovf_d     = ovf_q;
      unf_d     = unf_q;
      pend_d    = pend_q;
      lo_d      = lo_q;
      rd_live_d = rd_live_q;
      wptr_d    = wptr_q;
      rptr_d    = rptr_q;
      count_d   = count_q;

      if (rd_start) rd_live_d = 1'b1;
      else if (fin) rd_live_d = 1'b0;

      if (wr_go) begin
         if (pend_q) begin
            pend_d = 1'b0;
            if (full && !pop) ovf_d = 1'b1;
         end else begin
            lo_d   = wr_byte;
            pend_d = 1'b1;
         end
      end

      // pend doubles as the "low byte already read" marker.
      if (rd_go) begin
         if (!head_v_q) unf_d = unf_q | ERR_EN;
         else pend_d = ~pend_q;
      end

      if (push) wptr_d = wptr_q + AW'(1);
      if (pop)  rptr_d = rptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);

      if (ctrl_wr) begin
         dir_d    = sram_d_in[CT_DIR];
         irq_en_d = sram_d_in[CT_IRQEN];
         if (sram_d_in[CT_CLR]) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
         end
      end

      if (flush) begin
         wptr_d    = '0;
         rptr_d    = '0;
         count_d   = '0;
         pend_d    = 1'b0;
         rd_live_d = 1'b0;
      end
   end

   // Only words written before this edge are readable by the RAM now.
   assign head_v_d = ~flush & ((count_q - CW'(pop)) != '0);
   assign irq_d    = irq_en_q & (dir_q ? empty : half);

   always_ff @(posedge clk) begin
      if (!nrst) begin
         cs_q      <= 1'b0;
         dir_q     <= 1'b0;
         irq_en_q  <= 1'b0;
         ovf_q     <= 1'b0;
         unf_q     <= 1'b0;
         pend_q    <= 1'b0;
         lo_q      <= 8'h00;
         rd_live_q <= 1'b0;
         wptr_q    <= '0;
         rptr_q    <= '0;
         count_q   <= '0;
         head_v_q  <= 1'b0;
         irq_q     <= 1'b0;
      end else begin
         cs_q      <= sram_cs;
         dir_q     <= dir_d;
         irq_en_q  <= irq_en_d;
         ovf_q     <= ovf_d;
         unf_q     <= unf_d;
         pend_q    <= pend_d;
         lo_q      <= lo_d;
         rd_live_q <= rd_live_d;
         wptr_q    <= wptr_d;
         rptr_q    <= rptr_d;
         count_q   <= count_d;
         head_v_q  <= head_v_d;
         irq_q     <= irq_d;
      end
   end

   always_comb begin
      status           = 8'h00;
      status[ST_EMPTY] = empty;
      status[ST_FULL]  = full;
      status[ST_DIR]   = dir_q;
      status[ST_OVF]   = ovf_q;
      status[ST_UNF]   = unf_q;
      status[ST_PEND]  = pend_q;
      status[ST_HALF]  = half;
   end

   always_comb begin
      if (int'(count_q) > LVL_MAX) level_b = 8'(LVL_MAX);
      else level_b = 8'(count_q);
   end

   always_comb begin
      sram_d_out = 8'h00;
      if (sram_cs && sram_oe) begin
         unique case (sram_a)
            REG_DATA: begin
               if (!dir_q && head_v_q)
                  sram_d_out = pend_q ? q[15:8] : q[7:0];
            end
            REG_STATUS:  sram_d_out = status;
            REG_CONTROL: sram_d_out = {4'b0, irq_en_q, 1'b0, dir_q, 1'b0};
            default:     sram_d_out = level_b;
         endcase
      end
   end

   assign h_rd_valid = head_v_q & dir_q;
   assign h_rd_data  = h_rd_valid ? q : 16'h0000;
   assign h_wr_full  = full & ~dir_q;
   assign dir        = dir_q;
   assign irq        = irq_q;

endmodule

// File: tb/tb_ide_xfer_fifo.sv
// Self-checking bench for ide_xfer_fifo: random traffic in both
// directions against a queue-based model, plus directed corner cases.
module tb_ide_xfer_fifo;
   import ide_xfer_pkg::*;

   logic        clk = 1'b0;
   logic        nrst = 1'b0;
   logic [1:0]  sram_a = 2'd0;
   logic        sram_cs = 1'b0;
   logic        sram_oe = 1'b0;
   logic        sram_we = 1'b0;
   logic [7:0]  sram_d_in = 8'h00;
   logic [7:0]  sram_d_out;
   logic        sram_wait;
   logic [15:0] h_rd_data;
   logic        h_rd_valid;
   logic        h_rd_ack = 1'b0;
   logic [15:0] h_wr_data = 16'h0000;
   logic        h_wr_stb = 1'b0;
   logic        h_wr_full;
   logic        dir;
   logic        irq;

   int n_chk = 0;
   int n_err = 0;

   logic [15:0] mq[$];
   bit          m_dir, m_ovf, m_unf, m_pend, m_irqen;
   logic [7:0]  m_lo;

   always #5 clk = ~clk;

   ide_xfer_fifo dut (
      .clk        (clk),
      .nrst       (nrst),
      .sram_a     (sram_a),
      .sram_cs    (sram_cs),
      .sram_oe    (sram_oe),
      .sram_we    (sram_we),
      .sram_d_in  (sram_d_in),
      .sram_d_out (sram_d_out),
      .sram_wait  (sram_wait),
      .h_rd_data  (h_rd_data),
      .h_rd_valid (h_rd_valid),
      .h_rd_ack   (h_rd_ack),
      .h_wr_data  (h_wr_data),
      .h_wr_stb   (h_wr_stb),
      .h_wr_full  (h_wr_full),
      .dir        (dir),
      .irq        (irq)
   );

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] m_status();
      int n = mq.size();
      return {1'b0, (n >= 128), m_pend, m_unf, m_ovf, m_dir,
              (n == 256), (n == 0)};
   endfunction

   function automatic logic [7:0] m_level();
      return (mq.size() > 255) ? 8'd255 : 8'(mq.size());
   endfunction

   task automatic m_reset();
      mq.delete();
      m_dir = 0; m_ovf = 0; m_unf = 0; m_pend = 0; m_irqen = 0;
      m_lo = 8'h00;
   endtask

   task automatic m_ctrl(input logic [7:0] d);
      if (d[0] || (d[1] != m_dir)) begin
         mq.delete();
         m_pend = 0;
      end
      m_dir = d[1];
      if (d[2]) begin
         m_ovf = 0;
         m_unf = 0;
      end
      m_irqen = d[3];
   endtask

   task automatic m_wr_data(input logic [7:0] d);
      if (m_dir) begin
         if (!m_pend) begin
            m_lo = d;
            m_pend = 1;
         end else begin
            if (mq.size() < 256) mq.push_back({d, m_lo});
            else m_ovf = 1;
            m_pend = 0;
         end
      end
   endtask

   task automatic m_rd_data(output logic [7:0] e);
      if (m_dir) e = 8'h00;
      else if (mq.size() == 0) begin
         e = 8'h00;
         m_unf = 1;
      end else begin
         e = m_pend ? mq[0][15:8] : mq[0][7:0];
         if (m_pend) void'(mq.pop_front());
         m_pend = !m_pend;
      end
   endtask

   task automatic avr_wr(input logic [1:0] a, input logic [7:0] d);
      sram_cs = 1; sram_we = 1; sram_a = a; sram_d_in = d;
      tick();
      for (int k = 0; k < 64 && sram_wait; k++) tick();
      if (sram_wait) check("wr_wait_bound", sram_wait, 0);
      sram_cs = 0; sram_we = 0;
      tick();
   endtask

   task automatic avr_rd(input logic [1:0] a, output logic [7:0] d,
                         input bit stb, input logic [15:0] w);
      sram_cs = 1; sram_oe = 1; sram_a = a;
      #1;
      for (int k = 0; k < 64 && sram_wait; k++) tick();
      if (sram_wait) check("rd_wait_bound", sram_wait, 0);
      d = sram_d_out;
      tick();
      sram_cs = 0; sram_oe = 0;
      if (stb) begin
         h_wr_stb = 1;
         h_wr_data = w;
      end
      tick();
      h_wr_stb = 0;
   endtask

   task automatic ctrl(input logic [7:0] d);
      m_ctrl(d);
      avr_wr(REG_CONTROL, d);
   endtask

   task automatic wr_data(input logic [7:0] d);
      m_wr_data(d);
      avr_wr(REG_DATA, d);
   endtask

   task automatic rd_data(input string tag);
      logic [7:0] g, e;
      m_rd_data(e);
      avr_rd(REG_DATA, g, 0, 16'h0);
      check(tag, g, e);
   endtask

   task automatic chk_regs(input string tag);
      logic [7:0] g;
      avr_rd(REG_STATUS, g, 0, 16'h0);
      check({tag, "_status"}, g, m_status());
      avr_rd(REG_LEVEL, g, 0, 16'h0);
      check({tag, "_level"}, g, m_level());
   endtask

   task automatic h_push(input logic [15:0] w);
      h_wr_stb = 1; h_wr_data = w;
      tick();
      h_wr_stb = 0;
      if (!m_dir && mq.size() < 256) mq.push_back(w);
   endtask

   initial begin
      logic [7:0]  g, e;
      logic [15:0] w, x, last;
      int          n;

      m_reset();
      tick(); tick();
      nrst = 1;
      tick();
      check("rst_valid", h_rd_valid, 0);
      check("rst_full", h_wr_full, 0);
      check("rst_irq", irq, 0);
      check("rst_dir", dir, 0);
      check("rst_wait", sram_wait, 0);
      avr_rd(REG_STATUS, g, 0, 16'h0);
      check("rst_status", g, 8'h01);

      // AVR to host, latency of a single word
      ctrl(8'h02);
      check("dir1", dir, 1);
      rd_data("rd_in_dir1");
      wr_data(8'h34);
      m_wr_data(8'h12);
      sram_cs = 1; sram_we = 1; sram_a = REG_DATA; sram_d_in = 8'h12;
      tick();
      sram_cs = 0; sram_we = 0;
      check("lat_cyc1", h_rd_valid, 0);
      tick();
      check("lat_cyc2", h_rd_valid, 1);
      check("word_1234", h_rd_data, 16'h1234);
      h_rd_ack = 1;
      tick();
      h_rd_ack = 0;
      void'(mq.pop_front());
      avr_rd(REG_STATUS, g, 0, 16'h0);
      check("empty_after_ack", g[0], 1);
      check("status_after_ack", g, m_status());

      ctrl(8'h0A);
      check("irq_dir1_empty", irq, 1);
      avr_rd(REG_CONTROL, g, 0, 16'h0);
      check("ctrl_read", g, 8'h0A);
      ctrl(8'h02);
      tick();
      check("irq_off", irq, 0);

      // random AVR to host bursts with random host acks
      for (int r = 0; r < 3; r++) begin
         n = $urandom_range(1, 20);
         for (int i = 0; i < n; i++) begin
            w = 16'($urandom);
            wr_data(w[7:0]);
            wr_data(w[15:8]);
         end
         chk_regs("rnd1");
         for (int c = 0; c < 400 && mq.size() > 0; c++) begin
            check("rnd1_valid", h_rd_valid, 1);
            if (h_rd_valid) check("rnd1_data", h_rd_data, mq[0]);
            h_rd_ack = 1'($urandom_range(0, 1));
            if (h_rd_ack && h_rd_valid) void'(mq.pop_front());
            tick();
            h_rd_ack = 0;
         end
         check("rnd1_drained", mq.size(), 0);
      end

      // fill to full, overflow, clear, full-rate drain
      for (int i = 0; i < 256; i++) begin
         w = 16'($urandom);
         wr_data(w[7:0]);
         wr_data(w[15:8]);
      end
      avr_rd(REG_LEVEL, g, 0, 16'h0);
      check("full_level", g, 8'd255);
      chk_regs("full");
`ifndef IDE_XFER_FIFO_WAIT_EN
      wr_data(8'h55);
      wr_data(8'hAA);
      avr_rd(REG_STATUS, g, 0, 16'h0);
      check("ovf_full_bit", g[1], 1);
      check("ovf_bit", g[3], 1);
      check("ovf_status", g, m_status());
`endif
      ctrl(8'h06);
      avr_rd(REG_STATUS, g, 0, 16'h0);
      check("ovf_cleared", g[3], 0);
      check("full_kept", g[1], 1);
      h_rd_ack = 1;
      for (int i = 0; i < 256; i++) begin
         check("drain_valid", h_rd_valid, 1);
         if (mq.size() > 0) w = mq.pop_front();
         else w = 16'h0;
         check("drain_data", h_rd_data, w);
         tick();
      end
      h_rd_ack = 0;
      check("drain_empty", h_rd_valid, 0);

      // host to AVR
      ctrl(8'h00);
      check("dir0", dir, 0);
      h_push(16'hBEEF);
      h_push(16'hCAFE);
      tick(); tick();
      check("h_valid_dir0", h_rd_valid, 0);
      m_rd_data(e);
      avr_rd(REG_DATA, g, 0, 16'h0);
      check("rd_EF", g, 8'hEF);
      m_rd_data(e);
      avr_rd(REG_DATA, g, 0, 16'h0);
      check("rd_BE", g, 8'hBE);
      m_rd_data(e);
      avr_rd(REG_DATA, g, 0, 16'h0);
      check("rd_FE", g, 8'hFE);
      m_rd_data(e);
      avr_rd(REG_DATA, g, 0, 16'h0);
      check("rd_CA", g, 8'hCA);
`ifndef IDE_XFER_FIFO_WAIT_EN
      m_rd_data(e);
      avr_rd(REG_DATA, g, 0, 16'h0);
      check("rd_empty", g, 8'h00);
      avr_rd(REG_STATUS, g, 0, 16'h0);
      check("unf_bit", g[4], 1);
      check("unf_status", g, m_status());
      ctrl(8'h04);
`endif

      for (int r = 0; r < 3; r++) begin
         n = $urandom_range(1, 40);
         for (int i = 0; i < n; i++) begin
            h_push(16'($urandom));
            repeat ($urandom_range(0, 2)) tick();
         end
         tick(); tick();
         chk_regs("rnd0");
         for (int i = 0; i < 2 * n; i++) rd_data("rnd0_byte");
         chk_regs("rnd0_end");
      end

      // push at full in the same cycle as an AVR pop
      h_wr_stb = 1;
      for (int i = 0; i < 256; i++) begin
         h_wr_data = 16'($urandom);
         mq.push_back(h_wr_data);
         tick();
      end
      h_wr_stb = 0;
      tick(); tick();
      check("sim_full_pre", h_wr_full, 1);
      rd_data("sim_lo");
      x = 16'($urandom);
      m_rd_data(e);
      avr_rd(REG_DATA, g, 1, x);
      check("sim_hi", g, e);
      mq.push_back(x);
      check("sim_full_post", h_wr_full, 1);
      avr_rd(REG_STATUS, g, 0, 16'h0);
      check("sim_noovf", g[3], 0);
      check("sim_full_st", g[1], 1);
      last = 16'h0;
      for (int i = 0; i < 256; i++) begin
         m_rd_data(e);
         avr_rd(REG_DATA, g, 0, 16'h0);
         check("sim_rd_lo", g, e);
         last[7:0] = g;
         m_rd_data(e);
         avr_rd(REG_DATA, g, 0, 16'h0);
         check("sim_rd_hi", g, e);
         last[15:8] = g;
      end
      check("sim_last", last, x);
      chk_regs("sim_end");

`ifdef IDE_XFER_FIFO_WAIT_EN
      // stalled read released by a host push
      sram_cs = 1; sram_oe = 1; sram_a = REG_DATA;
      #1;
      check("wait_start", sram_wait, 1);
      tick();
      check("wait_held", sram_wait, 1);
      h_wr_stb = 1; h_wr_data = 16'h00AA;
      tick();
      h_wr_stb = 0;
      mq.push_back(16'h00AA);
      for (int k = 0; k < 8 && sram_wait; k++) tick();
      check("wait_drop", sram_wait, 0);
      check("wait_data", sram_d_out, 8'hAA);
      tick();
      sram_cs = 0; sram_oe = 0;
      tick();
      m_rd_data(e);
      avr_rd(REG_STATUS, g, 0, 16'h0);
      check("wait_no_unf", g[4], 0);
      check("wait_status", g, m_status());
`endif

      // reset in the middle of a transfer
      ctrl(8'h02);
      for (int i = 0; i < 5; i++) begin
         wr_data(8'($urandom));
         wr_data(8'($urandom));
      end
      check("pre_rst_valid", h_rd_valid, 1);
      nrst = 0;
      tick(); tick();
      nrst = 1;
      m_reset();
      check("mrst_valid", h_rd_valid, 0);
      check("mrst_wait", sram_wait, 0);
      check("mrst_dir", dir, 0);
      avr_rd(REG_STATUS, g, 0, 16'h0);
      check("mrst_status", g, 8'h01);
      avr_rd(REG_LEVEL, g, 0, 16'h0);
      check("mrst_level", g, 8'h00);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
